// File: rtl/uarc_pkg.sv
// Shared types for the UARC sender: op encoding and sender FSM states.
package uarc_pkg;

    typedef enum logic [1:0] {
        OP_KILL   = 2'd0,
        OP_INCEPT = 2'd1,
        OP_SEND   = 2'd2,
        OP_STREAM = 2'd3
    } uarc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } sender_state_t;

endpackage

// File: rtl/uarc_sender.sv
// UARC bus sender: issues one op to a multicast set of buses and collects per-bus acks.
//
//  state   | meaning
//  ST_IDLE | no transfer; request accepted when valid
//  ST_BUSY | strobe + enables driven, waiting for pending buses to ack
//  ST_GAP  | stream open between beats; global_stream held, enables off
module uarc_sender
    import uarc_pkg::*;
#(
    parameter int WORD_MAG    = 5,
    parameter int TOTAL_BUSES = 4,
    parameter int BEAT_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [1:0]                    req_op_i,
    input  logic [TOTAL_BUSES-1:0]        req_buses_i,
    input  logic                          req_last_i,
    input  logic [(1<<WORD_MAG)-1:0]      req_data_i,
    input  logic [(1<<WORD_MAG)-1:0]      req_self_perm_i,
    input  logic [(1<<WORD_MAG)-1:0]      req_self_addr_i,
    input  logic [(1<<WORD_MAG)-1:0]      req_incept_perm_i,
    input  logic [(1<<WORD_MAG)-1:0]      req_incept_addr_i,
    input  logic                          cancel_i,
    output logic                          done_o,
    output logic                          done_cancelled_o,
    output logic [TOTAL_BUSES-1:0]        done_unacked_o,
    output logic [BEAT_WIDTH-1:0]         stream_beats_o,
    output logic                          global_kill_o,
    output logic                          global_incept_o,
    output logic                          global_send_o,
    output logic                          global_stream_o,
    output logic [(1<<WORD_MAG)-1:0]      global_data_o,
    output logic [(1<<WORD_MAG)-1:0]      global_self_permission_o,
    output logic [(1<<WORD_MAG)-1:0]      global_self_address_o,
    output logic [(1<<WORD_MAG)-1:0]      global_incept_permission_o,
    output logic [(1<<WORD_MAG)-1:0]      global_incept_address_o,
    output logic [TOTAL_BUSES-1:0]        sender_enables_o,
    input  logic [TOTAL_BUSES-1:0]        sender_kill_acks_i,
    input  logic [TOTAL_BUSES-1:0]        sender_incept_acks_i,
    input  logic [TOTAL_BUSES-1:0]        sender_send_acks_i,
    input  logic [TOTAL_BUSES-1:0]        sender_stream_acks_i
);

    localparam int WORD_WIDTH = 1 << WORD_MAG;

    sender_state_t          state_q, state_d;
    uarc_op_t               op_q, op_d;
    logic [TOTAL_BUSES-1:0] pending_q, pending_d;
    logic [TOTAL_BUSES-1:0] tmask_q, tmask_d;
    logic                   last_q, last_d;
    logic [WORD_WIDTH-1:0]  data_q, data_d;
    logic [WORD_WIDTH-1:0]  sperm_q, sperm_d;
    logic [WORD_WIDTH-1:0]  saddr_q, saddr_d;
    logic [WORD_WIDTH-1:0]  iperm_q, iperm_d;
    logic [WORD_WIDTH-1:0]  iaddr_q, iaddr_d;
    logic [BEAT_WIDTH-1:0]  beats_q, beats_d;
    logic                   done_q, done_d;
    logic                   dcan_q, dcan_d;
    logic [TOTAL_BUSES-1:0] dun_q, dun_d;

    logic [TOTAL_BUSES-1:0] ack_vec;
    logic [TOTAL_BUSES-1:0] remaining;
    logic [BEAT_WIDTH-1:0]  beats_inc;
    logic                   active;

    // Only the ack vector matching the latched op can retire pending buses.
    always_comb begin
        ack_vec = '0;
        case (op_q)
            OP_KILL:   ack_vec = sender_kill_acks_i;
            OP_INCEPT: ack_vec = sender_incept_acks_i;
            OP_SEND:   ack_vec = sender_send_acks_i;
            OP_STREAM: ack_vec = sender_stream_acks_i;
            default:   ack_vec = '0;
        endcase
    end

    assign remaining = pending_q & ~ack_vec;
    assign beats_inc = (&beats_q) ? beats_q : beats_q + BEAT_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pending_d = pending_q;
        tmask_d   = tmask_q;
        last_d    = last_q;
        data_d    = data_q;
        sperm_d   = sperm_q;
        saddr_d   = saddr_q;
        iperm_d   = iperm_q;
        iaddr_d   = iaddr_q;
        beats_d   = beats_q;
        done_d    = 1'b0;
        dcan_d    = dcan_q;
        dun_d     = dun_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (|req_buses_i) begin
                        state_d   = ST_BUSY;
                        op_d      = uarc_op_t'(req_op_i);
                        pending_d = req_buses_i;
                        tmask_d   = req_buses_i;
                        last_d    = req_last_i;
                        data_d    = req_data_i;
                        sperm_d   = req_self_perm_i;
                        saddr_d   = req_self_addr_i;
                        iperm_d   = req_incept_perm_i;
                        iaddr_d   = req_incept_addr_i;
                        beats_d   = '0;
                    end else begin
                        done_d = 1'b1;
                        dcan_d = 1'b0;
                        dun_d  = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (cancel_i) begin
                    state_d   = ST_IDLE;
                    pending_d = '0;
                    done_d    = 1'b1;
                    dcan_d    = 1'b1;
                    dun_d     = pending_q;
                end else begin
                    pending_d = remaining;
                    if (remaining == '0) begin
                        if (op_q == OP_STREAM) begin
                            beats_d = beats_inc;
                        end
                        if (op_q == OP_STREAM && !last_q) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            dcan_d  = 1'b0;
                            dun_d   = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (cancel_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    dcan_d  = 1'b1;
                    dun_d   = '0;
                end else if (req_valid_i) begin
                    // Continuation beat: op and target set come from the opening beat.
                    state_d   = ST_BUSY;
                    pending_d = tmask_q;
                    last_d    = req_last_i;
                    data_d    = req_data_i;
                    sperm_d   = req_self_perm_i;
                    saddr_d   = req_self_addr_i;
                    iperm_d   = req_incept_perm_i;
                    iaddr_d   = req_incept_addr_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_KILL;
            pending_q <= '0;
            tmask_q   <= '0;
            last_q    <= 1'b0;
            data_q    <= '0;
            sperm_q   <= '0;
            saddr_q   <= '0;
            iperm_q   <= '0;
            iaddr_q   <= '0;
            beats_q   <= '0;
            done_q    <= 1'b0;
            dcan_q    <= 1'b0;
            dun_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pending_q <= pending_d;
            tmask_q   <= tmask_d;
            last_q    <= last_d;
            data_q    <= data_d;
            sperm_q   <= sperm_d;
            saddr_q   <= saddr_d;
            iperm_q   <= iperm_d;
            iaddr_q   <= iaddr_d;
            beats_q   <= beats_d;
            done_q    <= done_d;
            dcan_q    <= dcan_d;
            dun_q     <= dun_d;
        end
    end

    assign active                     = (state_q != ST_IDLE);
    assign req_ready_o                = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign global_kill_o              = active && (op_q == OP_KILL);
    assign global_incept_o            = active && (op_q == OP_INCEPT);
    assign global_send_o              = active && (op_q == OP_SEND);
    assign global_stream_o            = active && (op_q == OP_STREAM);
    assign sender_enables_o           = (state_q == ST_BUSY) ? pending_q : '0;
    assign global_data_o              = data_q;
    assign global_self_permission_o   = sperm_q;
    assign global_self_address_o      = saddr_q;
    assign global_incept_permission_o = iperm_q;
    assign global_incept_address_o    = iaddr_q;
    assign done_o                     = done_q;
    assign done_cancelled_o           = dcan_q;
    assign done_unacked_o             = dun_q;
    assign stream_beats_o             = beats_q;

endmodule
